// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg
//  Shared definitions for the frame scheduler: FSM state encoding, flash layout
//  defaults and small helpers for frame index sequencing and flash addressing.
package frame_scheduler_pkg;

  // Scheduler FSM states (2-bit encoding; 2'd3 is unused and recovers to IDLE)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_e;

  localparam logic [23:0] FLASH_BASE_DEFAULT  = 24'h800000;
  localparam int unsigned FRAME_SHIFT_DEFAULT = 13;

  // Next animation frame, wrapping count-1 -> 0 (>= also recovers an out-of-range index)
  function automatic logic [7:0] next_index(input logic [7:0] idx, input int unsigned count);
    logic [7:0] last;
    last = 8'(count - 1);
    if (idx >= last) begin
      return 8'd0;
    end else begin
      return idx + 8'd1;
    end
  endfunction

  // Flash start address of a frame: base + (idx << shift), truncated to 24 bits
  function automatic logic [23:0] load_address(input logic [23:0] base, input logic [7:0] idx,
                                               input int unsigned shift);
    logic [23:0] offset;
    offset = 24'(idx) << shift;
    return base + offset;
  endfunction

endpackage

// File: rtl/frame_scheduler_tick_gen.sv
// frame_scheduler_tick_gen
//  Frame-rate prescaler. o_tick is high for one cycle whenever the prescaler is
//  zero, after which it reloads PERIOD-1. Because reset clears the prescaler, the
//  first tick lands on the first cycle after reset release.
// Ports
//  i_clk    in  1  system clock
//  i_reset  in  1  asynchronous reset, active-high
//  o_tick   out 1  one-cycle frame tick
module frame_scheduler_tick_gen #(
  parameter int unsigned PERIOD = 4_800_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_d;

  assign o_tick = (presc_q == {CNT_W{1'b0}});

  // Prescaler next value: reload on tick, otherwise count down
  always_comb begin
    presc_d = presc_q;
    if (o_tick) begin
      presc_d = CNT_W'(PERIOD - 1);
    end else begin
      presc_d = presc_q - CNT_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= {CNT_W{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
//  Sequences animation playback over a double-buffered pixel RAM: one flash load
//  per frame tick into the back bank, bank swap only at a panel refresh boundary.
// Ports
//  i_clk, i_reset           clock, asynchronous active-high reset
//  i_load_done              loader pulse: frame fully written
//  i_panel_frame_end        driver pulse: refresh scan finished
//  o_load_stb/o_load_addr   start-load pulse and flash address (held through the load)
//  o_write_bank/o_display_bank  bank selects (always complementary)
//  o_frame_index            frame being / last loaded
//  o_swap_stb, o_overrun, o_timeout  one-cycle event pulses
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 48_000_000,
  parameter int unsigned FRAME_RATE_HZ = 10,
  parameter int unsigned FRAME_COUNT   = 12,
  parameter logic [23:0] FLASH_BASE    = FLASH_BASE_DEFAULT,
  parameter int unsigned FRAME_SHIFT   = FRAME_SHIFT_DEFAULT,
  parameter int unsigned LOAD_TIMEOUT  = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load_done,
  input  logic        i_panel_frame_end,
  output logic        o_load_stb,
  output logic [23:0] o_load_addr,
  output logic        o_write_bank,
  output logic        o_display_bank,
  output logic [7:0]  o_frame_index,
  output logic        o_swap_stb,
  output logic        o_overrun,
  output logic        o_timeout
);

  localparam int unsigned PERIOD = CLK_HZ / FRAME_RATE_HZ;
  localparam int unsigned TO_W   = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  logic tick;

  state_e          state_q,    state_d;
  logic            pending_q,  pending_d;
  logic [7:0]      index_q,    index_d;
  logic            bank_q,     bank_d;
  logic            load_stb_q, load_stb_d;
  logic [23:0]     addr_q,     addr_d;
  logic            swap_stb_q, swap_stb_d;
  logic            overrun_q,  overrun_d;
  logic            timeout_q,  timeout_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;

  frame_scheduler_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  // One-deep tick queue: IDLE consumes it; elsewhere a second tick overruns
  always_comb begin
    pending_d = pending_q;
    overrun_d = 1'b0;
    if (state_q == ST_IDLE) begin
      // A pending tick is served now; a fresh tick arriving alongside it stays queued
      pending_d = tick & pending_q;
    end else if (tick) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Scheduler FSM: next state, bank/index updates and event pulses
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    to_cnt_d   = to_cnt_q;
    load_stb_d = 1'b0;
    swap_stb_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          load_stb_d = 1'b1;
          addr_d     = load_address(FLASH_BASE, index_q, FRAME_SHIFT);
          to_cnt_d   = {TO_W{1'b0}};
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Completion wins over a timeout expiring in the same cycle
        if (i_load_done) begin
          state_d = ST_SWAP_WAIT;
        end else if (to_cnt_q == TO_W'(LOAD_TIMEOUT - 1)) begin
          // Abandoned frame: skip it without swapping so the panel keeps a whole image
          timeout_d = 1'b1;
          index_d   = next_index(index_q, FRAME_COUNT);
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_SWAP_WAIT: begin
        if (i_panel_frame_end) begin
          bank_d     = ~bank_q;
          swap_stb_d = 1'b1;
          index_d    = next_index(index_q, FRAME_COUNT);
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_SWAP_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      index_q    <= 8'd0;
      bank_q     <= 1'b0;
      load_stb_q <= 1'b0;
      addr_q     <= 24'd0;
      swap_stb_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      to_cnt_q   <= {TO_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      index_q    <= index_d;
      bank_q     <= bank_d;
      load_stb_q <= load_stb_d;
      addr_q     <= addr_d;
      swap_stb_q <= swap_stb_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign o_load_stb     = load_stb_q;
  assign o_load_addr    = addr_q;
  assign o_display_bank = bank_q;
  assign o_write_bank   = ~bank_q;
  assign o_frame_index  = index_q;
  assign o_swap_stb     = swap_stb_q;
  assign o_overrun      = overrun_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
//  Directed bench for frame_scheduler with PERIOD 10, FRAME_COUNT 3, LOAD_TIMEOUT 20.
//  Cycle 0 is the first cycle after reset release; ticks land on cycles 0,10,20,...
`timescale 1ns/1ps
module tb_frame_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_load_done;
  logic        i_panel_frame_end;
  logic        o_load_stb;
  logic [23:0] o_load_addr;
  logic        o_write_bank;
  logic        o_display_bank;
  logic [7:0]  o_frame_index;
  logic        o_swap_stb;
  logic        o_overrun;
  logic        o_timeout;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always #5 i_clk = ~i_clk;

  frame_scheduler #(
    .CLK_HZ        (100),
    .FRAME_RATE_HZ (10),
    .FRAME_COUNT   (3),
    .FLASH_BASE    (24'h800000),
    .FRAME_SHIFT   (13),
    .LOAD_TIMEOUT  (20)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_load_done       (i_load_done),
    .i_panel_frame_end (i_panel_frame_end),
    .o_load_stb        (o_load_stb),
    .o_load_addr       (o_load_addr),
    .o_write_bank      (o_write_bank),
    .o_display_bank    (o_display_bank),
    .o_frame_index     (o_frame_index),
    .o_swap_stb        (o_swap_stb),
    .o_overrun         (o_overrun),
    .o_timeout         (o_timeout)
  );

  // Advance one cycle; input pulses last exactly the cycle they were set in
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    i_load_done       = 1'b0;
    i_panel_frame_end = 1'b0;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    i_reset           = 1'b1;
    i_load_done       = 1'b0;
    i_panel_frame_end = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    cyc     = 0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_load_done = 1'b0; i_panel_frame_end = 1'b0;
    #3;
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL rst_stb got %0b want 0", o_load_stb); end
    tests++; if (o_load_addr !== 24'h000000) begin failed++; $display("FAIL rst_addr got %h want 000000", o_load_addr); end
    tests++; if (o_write_bank !== 1'b1) begin failed++; $display("FAIL rst_wbank got %0b want 1", o_write_bank); end
    tests++; if (o_display_bank !== 1'b0) begin failed++; $display("FAIL rst_dbank got %0b want 0", o_display_bank); end
    tests++; if (o_frame_index !== 8'd0) begin failed++; $display("FAIL rst_index got %0d want 0", o_frame_index); end
    tests++; if ({o_swap_stb, o_overrun, o_timeout} !== 3'b000) begin failed++; $display("FAIL rst_pulses got %b want 000", {o_swap_stb, o_overrun, o_timeout}); end
    do_reset();
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL s1_stb_c0 got %0b want 0", o_load_stb); end
    goto_cyc(1);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s1_stb_c1 got %0b want 1", o_load_stb); end
    tests++; if (o_load_addr !== 24'h800000) begin failed++; $display("FAIL s1_addr got %h want 800000", o_load_addr); end
    goto_cyc(2);
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL s1_stb_c2 got %0b want 0", o_load_stb); end
    tests++; if (o_load_addr !== 24'h800000) begin failed++; $display("FAIL s1_addr_hold got %h want 800000", o_load_addr); end
    goto_cyc(5); i_load_done = 1'b1;
    goto_cyc(8); i_panel_frame_end = 1'b1;
    goto_cyc(9);
    tests++; if (o_swap_stb !== 1'b1) begin failed++; $display("FAIL s1_swap got %0b want 1", o_swap_stb); end
    tests++; if ({o_display_bank, o_write_bank} !== 2'b10) begin failed++; $display("FAIL s1_banks got %b want 10", {o_display_bank, o_write_bank}); end
    tests++; if (o_frame_index !== 8'd1) begin failed++; $display("FAIL s1_index got %0d want 1", o_frame_index); end
    goto_cyc(10);
    tests++; if (o_swap_stb !== 1'b0) begin failed++; $display("FAIL s1_swap_c10 got %0b want 0", o_swap_stb); end
  endtask

  task automatic test_frame_sequence();
    logic [23:0] exp_addr [4];
    logic [7:0]  exp_idx  [4];
    exp_addr = '{24'h800000, 24'h802000, 24'h804000, 24'h800000};
    exp_idx  = '{8'd1, 8'd2, 8'd0, 8'd1};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      goto_cyc(10 * f + 1);
      tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s2_stb f%0d got %0b want 1", f, o_load_stb); end
      tests++; if (o_load_addr !== exp_addr[f]) begin failed++; $display("FAIL s2_addr f%0d got %h want %h", f, o_load_addr, exp_addr[f]); end
      goto_cyc(10 * f + 5); i_load_done = 1'b1;
      goto_cyc(10 * f + 8); i_panel_frame_end = 1'b1;
      goto_cyc(10 * f + 9);
      tests++; if (o_swap_stb !== 1'b1) begin failed++; $display("FAIL s2_swap f%0d got %0b want 1", f, o_swap_stb); end
      tests++; if (o_frame_index !== exp_idx[f]) begin failed++; $display("FAIL s2_index f%0d got %0d want %0d", f, o_frame_index, exp_idx[f]); end
      tests++; if (o_display_bank !== ((f % 2) == 0)) begin failed++; $display("FAIL s2_dbank f%0d got %0b want %0b", f, o_display_bank, ((f % 2) == 0)); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    goto_cyc(5); i_load_done = 1'b1;
    goto_cyc(11);
    tests++; if (o_overrun !== 1'b0) begin failed++; $display("FAIL s3_ovr_c11 got %0b want 0", o_overrun); end
    goto_cyc(21);
    tests++; if (o_overrun !== 1'b1) begin failed++; $display("FAIL s3_ovr_c21 got %0b want 1", o_overrun); end
    goto_cyc(22);
    tests++; if (o_overrun !== 1'b0) begin failed++; $display("FAIL s3_ovr_c22 got %0b want 0", o_overrun); end
    goto_cyc(33); i_panel_frame_end = 1'b1;
    goto_cyc(34);
    tests++; if (o_swap_stb !== 1'b1) begin failed++; $display("FAIL s3_swap got %0b want 1", o_swap_stb); end
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL s3_stb_c34 got %0b want 0", o_load_stb); end
    goto_cyc(35);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s3_stb_c35 got %0b want 1", o_load_stb); end
    tests++; if (o_load_addr !== 24'h802000) begin failed++; $display("FAIL s3_addr got %h want 802000", o_load_addr); end
    tests++; if (o_frame_index !== 8'd1) begin failed++; $display("FAIL s3_index got %0d want 1", o_frame_index); end
  endtask

  task automatic test_timeout();
    do_reset();
    goto_cyc(12); i_panel_frame_end = 1'b1;
    goto_cyc(13);
    tests++; if ({o_swap_stb, o_display_bank} !== 2'b00) begin failed++; $display("FAIL s4_fe_in_load got %b want 00", {o_swap_stb, o_display_bank}); end
    goto_cyc(20);
    tests++; if (o_timeout !== 1'b0) begin failed++; $display("FAIL s4_to_c20 got %0b want 0", o_timeout); end
    goto_cyc(21);
    tests++; if (o_timeout !== 1'b1) begin failed++; $display("FAIL s4_to_c21 got %0b want 1", o_timeout); end
    tests++; if (o_swap_stb !== 1'b0) begin failed++; $display("FAIL s4_swap got %0b want 0", o_swap_stb); end
    tests++; if ({o_display_bank, o_write_bank} !== 2'b01) begin failed++; $display("FAIL s4_banks got %b want 01", {o_display_bank, o_write_bank}); end
    tests++; if (o_frame_index !== 8'd1) begin failed++; $display("FAIL s4_index got %0d want 1", o_frame_index); end
    i_load_done = 1'b1;
    goto_cyc(22);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s4_stb_c22 got %0b want 1", o_load_stb); end
    tests++; if (o_load_addr !== 24'h802000) begin failed++; $display("FAIL s4_addr got %h want 802000", o_load_addr); end
    tests++; if (o_timeout !== 1'b0) begin failed++; $display("FAIL s4_to_c22 got %0b want 0", o_timeout); end
    goto_cyc(42);
    tests++; if (o_timeout !== 1'b1) begin failed++; $display("FAIL s4_to_c42 got %0b want 1", o_timeout); end
    tests++; if (o_frame_index !== 8'd2) begin failed++; $display("FAIL s4_index2 got %0d want 2", o_frame_index); end
  endtask

  task automatic test_tick_with_frame_end();
    do_reset();
    goto_cyc(5); i_load_done = 1'b1;
    goto_cyc(10); i_panel_frame_end = 1'b1;
    goto_cyc(11);
    tests++; if (o_swap_stb !== 1'b1) begin failed++; $display("FAIL s5_swap got %0b want 1", o_swap_stb); end
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL s5_stb_c11 got %0b want 0", o_load_stb); end
    tests++; if (o_display_bank !== 1'b1) begin failed++; $display("FAIL s5_dbank got %0b want 1", o_display_bank); end
    goto_cyc(12);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s5_stb_c12 got %0b want 1", o_load_stb); end
    tests++; if (o_load_addr !== 24'h802000) begin failed++; $display("FAIL s5_addr got %h want 802000", o_load_addr); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    goto_cyc(5); i_load_done = 1'b1;
    goto_cyc(8); i_panel_frame_end = 1'b1;
    goto_cyc(11);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s6_stb_pre got %0b want 1", o_load_stb); end
    #2;
    i_reset = 1'b1;
    #1;
    tests++; if (o_load_stb !== 1'b0) begin failed++; $display("FAIL s6_stb_rst got %0b want 0", o_load_stb); end
    tests++; if (o_load_addr !== 24'h000000) begin failed++; $display("FAIL s6_addr_rst got %h want 000000", o_load_addr); end
    tests++; if ({o_display_bank, o_write_bank} !== 2'b01) begin failed++; $display("FAIL s6_banks_rst got %b want 01", {o_display_bank, o_write_bank}); end
    tests++; if (o_frame_index !== 8'd0) begin failed++; $display("FAIL s6_index_rst got %0d want 0", o_frame_index); end
    do_reset();
    goto_cyc(1);
    tests++; if (o_load_stb !== 1'b1) begin failed++; $display("FAIL s6_restart_stb got %0b want 1", o_load_stb); end
    tests++; if (o_load_addr !== 24'h800000) begin failed++; $display("FAIL s6_restart_addr got %h want 800000", o_load_addr); end
  endtask

  initial begin
    test_reset();
    test_frame_sequence();
    test_overrun();
    test_timeout();
    test_tick_with_frame_end();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
